lsu_bus_controller: RTL and testbench

LSU_BUS_CONTROLLER -- requirements
Module: lsu_bus_controller

---
 rtl/lsu_bus_controller.sv | 167 ++++++++++++++++
 tb/tb_lsu_bus_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_controller.sv
// Load/store unit bus controller: turns one core load/store into a single bus
// transaction, formatting byte lanes on the way out and load data on the way back.
package lsu_bus_controller_pkg;
    typedef enum logic [3:0] {
        LS_N_A = 4'd0,
        L_B, L_H, L_W, L_BU, L_HU,
        S_B, S_H, S_W
    } load_store_type_e;
endpackage

// Bus handshake: bus_req_o is valid and bus_gnt_i is ready; the request fields stay
// stable from the first REQ cycle until the cycle where req and gnt are both high.
// bus_rvalid_i (with bus_rdata_i/bus_err_i) is only honoured in WAIT.
module lsu_bus_controller
    import lsu_bus_controller_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  load_store_type_e ls_type_i,
    input  logic [XLEN-1:0]  addr_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic             stall_o,
    output logic [XLEN-1:0]  rdata_o,
    output logic             fault_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [XLEN-1:0]  bus_addr_o,
    output logic [3:0]       bus_be_o,
    output logic [XLEN-1:0]  bus_wdata_o,
    input  logic             bus_gnt_i,
    input  logic             bus_rvalid_i,
    input  logic [XLEN-1:0]  bus_rdata_i,
    input  logic             bus_err_i,
    output logic [1:0]       dbg_state_o
);

    // Debug encoding: IDLE=0, REQ=1, WAIT=2, DONE=3.
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_e;

    state_e           state_q, state_d;
    load_store_type_e type_q;
    logic [XLEN-1:0]  addr_q, wdata_q, rdata_q;
    logic [1:0]       off_q;
    logic [3:0]       be_q;
    logic             we_q, fault_q;
    logic [7:0]       tmo_q;

    logic             is_store, misaligned, access, timeout_hit;
    logic [3:0]       be_fmt;
    logic [XLEN-1:0]  wdata_fmt, rdata_fmt;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    always_comb begin
        is_store   = ls_type_i inside {S_B, S_H, S_W};
        misaligned = 1'b0;
        be_fmt     = 4'b0000;
        wdata_fmt  = wdata_i;
        case (ls_type_i)
            L_B, L_BU, S_B: be_fmt = 4'b0001 << addr_i[1:0];
            L_H, L_HU, S_H: begin
                be_fmt     = 4'b0011 << addr_i[1:0];
                misaligned = addr_i[0];
            end
            L_W, S_W: begin
                be_fmt     = 4'b1111;
                misaligned = addr_i[1:0] != 2'b00;
            end
            default: ;
        endcase
        case (ls_type_i)
            S_B:     wdata_fmt = {4{wdata_i[7:0]}};
            S_H:     wdata_fmt = {2{wdata_i[15:0]}};
            default: ;
        endcase
        access      = (ls_type_i != LS_N_A) && !misaligned;
        timeout_hit = (state_q == ST_REQ || state_q == ST_WAIT) &&
                      (tmo_q == 8'(TIMEOUT_CYCLES - 1));
    end

    // Load data is formatted from the offset captured at issue, not the live address.
    always_comb begin
        byte_sel  = bus_rdata_i[{off_q, 3'b000} +: 8];
        half_sel  = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        rdata_fmt = bus_rdata_i;
        case (type_q)
            L_B:     rdata_fmt = {{24{byte_sel[7]}}, byte_sel};
            L_BU:    rdata_fmt = {24'b0, byte_sel};
            L_H:     rdata_fmt = {{16{half_sel[15]}}, half_sel};
            L_HU:    rdata_fmt = {16'b0, half_sel};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Timeout wins over a grant or response arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access) state_d = ST_REQ;
            ST_REQ: begin
                if (timeout_hit)    state_d = ST_DONE;
                else if (bus_gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (timeout_hit)       state_d = ST_DONE;
                else if (bus_rvalid_i) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o     = !rst_i && ((state_q == ST_IDLE && access) ||
                                 state_q == ST_REQ || state_q == ST_WAIT);
        fault_o     = !rst_i && ((state_q == ST_IDLE && ls_type_i != LS_N_A && misaligned) ||
                                 (state_q == ST_DONE && fault_q));
        bus_req_o   = state_q == ST_REQ;
        bus_we_o    = we_q;
        bus_addr_o  = addr_q;
        bus_be_o    = be_q;
        bus_wdata_o = wdata_q;
        rdata_o     = rdata_q;
        dbg_state_o = state_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            type_q  <= LS_N_A;
            addr_q  <= '0;
            off_q   <= 2'b00;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            tmo_q   <= 8'd0;
            rdata_q <= '0;
        end else if (state_q == ST_IDLE && access) begin
            type_q  <= ls_type_i;
            addr_q  <= {addr_i[XLEN-1:2], 2'b00};
            off_q   <= addr_i[1:0];
            be_q    <= be_fmt;
            wdata_q <= wdata_fmt;
            we_q    <= is_store;
            fault_q <= 1'b0;
            tmo_q   <= 8'd0;
        end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
            tmo_q <= tmo_q + 8'd1;
            if (timeout_hit) begin
                fault_q <= 1'b1;
                if (!we_q) rdata_q <= '0;
            end else if (state_q == ST_WAIT && bus_rvalid_i) begin
                fault_q <= bus_err_i;
                if (!we_q) rdata_q <= rdata_fmt;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_controller.sv
// Bench for lsu_bus_controller: directed vector table, multi-cycle corner sequences
// and random transactions checked against an arithmetic reference model.
module tb_lsu_bus_controller;
    import lsu_bus_controller_pkg::*;

    typedef struct {
        load_store_type_e t;
        logic [31:0] addr, wdata, rdata;
        int          gnt_dly, rv_dly;
        logic [3:0]  be;
        logic [31:0] bus_addr, bus_wdata, rdata_exp;
        bit          mis;
        int          stall;
    } vec_t;

    logic             clk = 1'b0, rst_i = 1'b1;
    load_store_type_e ls_type_i = LS_N_A;
    logic [31:0]      addr_i = '0, wdata_i = '0, bus_rdata_i = '0;
    logic             bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;

    logic        stall_o, fault_o, bus_req_o, bus_we_o;
    logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic [1:0]  dbg_state_o;
    logic        t_stall, t_fault, t_bus_req, t_bus_we;
    logic [31:0] t_rdata, t_bus_addr, t_bus_wdata;
    logic [3:0]  t_bus_be;
    logic [1:0]  t_dbg;

    int          n_checks = 0, n_errors = 0;
    logic [31:0] model_last = '0;
    logic [31:0] exp_q[$];
    vec_t        tbl[10];

    lsu_bus_controller dut (
        .clk_i(clk), .rst_i(rst_i), .ls_type_i(ls_type_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .fault_o(fault_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i), .dbg_state_o(dbg_state_o));

    lsu_bus_controller #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk_i(clk), .rst_i(rst_i), .ls_type_i(ls_type_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(t_stall), .rdata_o(t_rdata), .fault_o(t_fault), .bus_req_o(t_bus_req),
        .bus_we_o(t_bus_we), .bus_addr_o(t_bus_addr), .bus_be_o(t_bus_be),
        .bus_wdata_o(t_bus_wdata), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i), .dbg_state_o(t_dbg));

    // Clock and reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        ls_type_i = LS_N_A; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        model_last = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: access rules written as plain arithmetic.
    function automatic vec_t model_vec(input load_store_type_e t, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [31:0] rd,
                                       input int g, input int r);
        vec_t v;
        int size, off, m;
        logic [31:0] sh;
        v.t = t; v.addr = a; v.wdata = wd; v.rdata = rd; v.gnt_dly = g; v.rv_dly = r;
        size = (t inside {L_B, L_BU, S_B}) ? 1 : (t inside {L_H, L_HU, S_H}) ? 2 : 4;
        off = int'(a % 4);
        v.mis = (a % size) != 0;
        m = ((1 << size) - 1) << off;
        v.be = m[3:0];
        v.bus_addr = a - (a % 4);
        v.bus_wdata = (t == S_B) ? (wd & 32'hFF) * 32'h01010101 :
                      (t == S_H) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        sh = rd >> (8 * off);
        case (t)
            L_B, L_BU: begin
                v.rdata_exp = sh & 32'hFF;
                if (t == L_B && v.rdata_exp >= 128) v.rdata_exp = v.rdata_exp | 32'hFFFFFF00;
            end
            L_H, L_HU: begin
                v.rdata_exp = sh & 32'hFFFF;
                if (t == L_H && v.rdata_exp >= 32768) v.rdata_exp = v.rdata_exp | 32'hFFFF0000;
            end
            L_W:     v.rdata_exp = rd;
            default: v.rdata_exp = model_last;
        endcase
        v.stall = v.mis ? 0 : g + r + 3;
        return v;
    endfunction

    // Driver: one core access plus the bus responder; checks every phase.
    task automatic do_access(input vec_t v, input bit err);
        int   stall_cnt = 0;
        logic st = v.t inside {S_B, S_H, S_W};
        ls_type_i = v.t; addr_i = v.addr; wdata_i = v.wdata;
        @(negedge clk);
        if (v.mis) begin
            chk("mis_fault", fault_o, 1'b1);
            chk("mis_stall", stall_o, 1'b0);
            chk("mis_req", bus_req_o, 1'b0);
            step();
            ls_type_i = LS_N_A;
            @(negedge clk);
            chk("mis_idle", dbg_state_o, 2'd0);
            chk("mis_req_after", bus_req_o, 1'b0);
            step();
            return;
        end
        exp_q.push_back(v.rdata_exp);
        chk("issue_fault", fault_o, 1'b0);
        if (stall_o) stall_cnt++;
        step();
        for (int i = 0; i <= v.gnt_dly; i++) begin
            bus_gnt_i = (i == v.gnt_dly);
            @(negedge clk);
            if (stall_o) stall_cnt++;
            chk("req", bus_req_o, 1'b1);
            chk("addr", bus_addr_o, v.bus_addr);
            chk("be", bus_be_o, v.be);
            chk("we", bus_we_o, st);
            if (st) chk("wdata", bus_wdata_o, v.bus_wdata);
            step();
        end
        bus_gnt_i = 1'b0;
        for (int j = 0; j <= v.rv_dly; j++) begin
            bus_rvalid_i = (j == v.rv_dly);
            bus_rdata_i  = (j == v.rv_dly) ? v.rdata : $urandom;
            bus_err_i    = (j == v.rv_dly) ? err : 1'($urandom);
            @(negedge clk);
            if (stall_o) stall_cnt++;
            chk("wait_req", bus_req_o, 1'b0);
            step();
        end
        bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        @(negedge clk);
        chk("done_stall", stall_o, 1'b0);
        chk("done_fault", fault_o, err);
        chk("done_rdata", rdata_o, exp_q.pop_front());
        chk("stall_cycles", stall_cnt, v.stall);
        step();
        ls_type_i = LS_N_A;
        model_last = v.rdata_exp;
    endtask

    // Drives the TIMEOUT_CYCLES=4 instance to timeout, optionally granting on the last cycle.
    task automatic timeout_seq(input bit gnt_last);
        ls_type_i = L_W; addr_i = 32'h44;
        @(negedge clk);
        chk("to_issue_stall", t_stall, 1'b1);
        step();
        for (int k = 0; k < 4; k++) begin
            bus_gnt_i = gnt_last && (k == 3);
            @(negedge clk);
            chk("to_req", t_bus_req, 1'b1);
            step();
        end
        bus_gnt_i = 1'b0;
        @(negedge clk);
        chk("to_fault", t_fault, 1'b1);
        chk("to_stall", t_stall, 1'b0);
        chk("to_rdata", t_rdata, 32'h0);
        chk("to_req_done", t_bus_req, 1'b0);
        step();
        ls_type_i = LS_N_A;
        @(negedge clk);
        chk("to_req_after", t_bus_req, 1'b0);
        chk("to_fault_after", t_fault, 1'b0);
        chk("to_idle", t_dbg, 2'd0);
        step();
    endtask

    initial begin
        load_store_type_e types[8] = '{L_B, L_H, L_W, L_BU, L_HU, S_B, S_H, S_W};

        //          type  addr    wdata         rdata         g  r  be       bus_addr  bus_wdata     rdata_exp   mis stall
        tbl[0] = '{L_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 4'b1111, 32'h100,  32'h0,        32'hDEADBEEF, 0, 4};
        tbl[1] = '{L_B,  32'h103, 32'h0,        32'h80FFFFFF, 1, 0, 4'b1000, 32'h100,  32'h0,        32'hFFFFFF80, 0, 4};
        tbl[2] = '{L_BU, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 4'b1000, 32'h100,  32'h0,        32'h00000080, 0, 3};
        tbl[3] = '{S_H,  32'h202, 32'h1234ABCD, 32'h0,        2, 1, 4'b1100, 32'h200,  32'hABCDABCD, 32'h00000080, 0, 6};
        tbl[4] = '{L_W,  32'h101, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,    32'h0,        32'h0,        1, 0};
        tbl[5] = '{S_H,  32'h003, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,    32'h0,        32'h0,        1, 0};
        tbl[6] = '{L_H,  32'h102, 32'h0,        32'h80011234, 0, 2, 4'b1100, 32'h100,  32'h0,        32'hFFFF8001, 0, 5};
        tbl[7] = '{L_HU, 32'h000, 32'h0,        32'h1234F00D, 3, 0, 4'b0011, 32'h0,    32'h0,        32'h0000F00D, 0, 6};
        tbl[8] = '{S_B,  32'h305, 32'h000000A5, 32'h0,        0, 0, 4'b0010, 32'h304,  32'hA5A5A5A5, 32'h0000F00D, 0, 3};
        tbl[9] = '{S_W,  32'h308, 32'hCAFEF00D, 32'h0,        1, 1, 4'b1111, 32'h308,  32'hCAFEF00D, 32'h0000F00D, 0, 5};

        // Outputs held at zero while reset is high, even with an access presented.
        ls_type_i = L_W; addr_i = 32'h101;
        #3;
        chk("rst_fault", fault_o, 1'b0);
        addr_i = 32'h100;
        #1;
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_req", bus_req_o, 1'b0);
        chk("rst_we", bus_we_o, 1'b0);
        chk("rst_be", bus_be_o, 4'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_state", dbg_state_o, 2'd0);
        do_reset();

        // Stray responses in IDLE are ignored.
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF; bus_err_i = 1'b1;
        repeat (2) step();
        bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        @(negedge clk);
        chk("stray_rdata", rdata_o, 32'h0);
        chk("stray_state", dbg_state_o, 2'd0);
        chk("stray_fault", fault_o, 1'b0);
        step();

        foreach (tbl[i]) do_access(tbl[i], 1'b0);

        // Reset while waiting for a response, then a late response.
        ls_type_i = L_W; addr_i = 32'h80;
        step();
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("rw_stall", stall_o, 1'b0);
        chk("rw_req", bus_req_o, 1'b0);
        chk("rw_be", bus_be_o, 4'h0);
        chk("rw_addr", bus_addr_o, 32'h0);
        chk("rw_rdata", rdata_o, 32'h0);
        chk("rw_state", dbg_state_o, 2'd0);
        ls_type_i = LS_N_A;
        step();
        rst_i = 1'b0; model_last = '0;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF; bus_err_i = 1'b1;
        @(negedge clk);
        chk("late_fault", fault_o, 1'b0);
        chk("late_stall", stall_o, 1'b0);
        step();
        bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        @(negedge clk);
        chk("late_rdata", rdata_o, 32'h0);
        chk("late_state", dbg_state_o, 2'd0);
        step();

        // Timeout without grant, then grant colliding with timeout.
        do_reset();
        do_access(model_vec(L_W, 32'h40, 32'h0, 32'h5555AAAA, 0, 0), 1'b0);
        chk("t_pre_rdata", t_rdata, 32'h5555AAAA);
        timeout_seq(1'b0);
        do_reset();
        do_access(model_vec(L_W, 32'h40, 32'h0, 32'h12345678, 0, 0), 1'b0);
        chk("t_pre_rdata2", t_rdata, 32'h12345678);
        timeout_seq(1'b1);
        do_reset();

        // Random transactions against the model.
        for (int n = 0; n < 150; n++) begin
            vec_t v;
            v = model_vec(types[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3));
            do_access(v, $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
